// File: rtl/vend_pkg.sv
// vend_pkg: definitions shared by the vending controller (drink_FSM) and
// the change dispenser. It holds the coin codes on the change bus, the
// payout state encoding, and a decoder from coin code to coin count.
package vend_pkg;

  // Coin codes on the 2-bit change bus; 2'd3 is never legal
  localparam logic [1:0] COIN_0   = 2'd0;
  localparam logic [1:0] COIN_1   = 2'd1;
  localparam logic [1:0] COIN_2   = 2'd2;
  localparam logic [1:0] COIN_BAD = 2'd3;

  // Payout handshake states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    REL   = 2'd2,
    FAULT = 2'd3
  } pay_state_e;

  // Number of one-unit coins owed for a change code; the illegal code adds nothing
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    logic [1:0] val;
    case (code)
      COIN_0:  val = 2'd0;
      COIN_1:  val = 2'd1;
      COIN_2:  val = 2'd2;
      default: val = 2'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch: a loadable down-counter whose output stays high while the
// count is nonzero. A load restarts the count at PULSE_LEN, including while
// a pulse is already running (retrigger). Loads are never queued.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   load       - start or restart the pulse
//   pulse      - registered output, high for PULSE_LEN cycles after the last load
//   pulse_next - value pulse takes on the next edge
module pulse_stretch
  import vend_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic pulse,
  output logic pulse_next
);

  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(PULSE_LEN);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] ZERO     = CW'(0);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          pulse_r;

  // Next count: load wins; otherwise count down toward zero
  always_comb begin
    cnt_next_s = cnt_r;
    if (load) begin
      cnt_next_s = LOAD_VAL;
    end else if (cnt_r != ZERO) begin
      cnt_next_s = cnt_r - ONE;
    end else begin
      cnt_next_s = ZERO;
    end
  end

  assign pulse_next = (cnt_next_s != ZERO);

  // Count and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= ZERO;
      pulse_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_next_s;
      pulse_r <= pulse_next;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: drives the coin hopper and the drink motor. The change
// and drink signals from drink_FSM are sampled on every edge. Owed coins are
// kept in a saturating counter, and each coin is paid out with a four-phase
// req/ack handshake.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   change[1:0] - coins owed this cycle (0..2, 3 ignored)
//   drink       - vend event, starts or restarts the motor pulse
//   hopper_ack  - hopper acknowledge
//   hopper_req  - request one coin
//   drink_motor - drink actuator pulse
//   pending     - coins still owed
//   busy        - work outstanding (coins, handshake or motor pulse)
//   overflow    - sticky: a change add saturated pending
//   fault       - sticky: hopper did not answer in time, payout stopped
//   coins_paid  - wrapping count of completed handshakes
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int DRINK_PULSE = 4,
  parameter int PAID_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        change,
  input  logic              drink,
  input  logic              hopper_ack,
  output logic              hopper_req,
  output logic              drink_motor,
  output logic [CNT_W-1:0]  pending,
  output logic              busy,
  output logic              overflow,
  output logic              fault,
  output logic [PAID_W-1:0] coins_paid
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   TMR_ZERO  = TMR_W'(0);
  localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W+1:0]   PEND_MAX  = {2'b00, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0]   PEND_ZERO = CNT_W'(0);
  localparam logic [PAID_W-1:0]  PAID_ZERO = PAID_W'(0);

  pay_state_e        state_r, state_next_s;
  logic [TMR_W-1:0]  timer_r, timer_next_s;
  logic [CNT_W-1:0]  pending_r, pending_next_s;
  logic [CNT_W+1:0]  sum_s;
  logic              dec_s;
  logic              sat_s;
  logic              overflow_r;
  logic              fault_r;
  logic              hopper_req_r;
  logic              busy_r;
  logic [PAID_W-1:0] coins_paid_r;
  logic              motor_next_s;

  // A coin is complete when the hopper has released ack after a grant
  assign dec_s = (state_r == REL) && !hopper_ack;

  // Pending update: add and decrement land together, result saturates.
  // The sum is two bits wider so that a saturating add is detectable.
  always_comb begin
    sum_s = {2'b00, pending_r}
          + {{CNT_W{1'b0}}, coin_value(change)}
          - {{(CNT_W+1){1'b0}}, dec_s};
    if (sum_s > PEND_MAX) begin
      pending_next_s = {CNT_W{1'b1}};
      sat_s          = 1'b1;
    end else begin
      pending_next_s = sum_s[CNT_W-1:0];
      sat_s          = 1'b0;
    end
  end

  // Payout FSM next state and timer; timer restarts on every transition
  always_comb begin
    state_next_s = state_r;
    timer_next_s = TMR_ZERO;
    case (state_r)
      IDLE: begin
        if ((pending_r != PEND_ZERO) && !fault_r) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (hopper_ack) begin
          state_next_s = REL;
        end else if (timer_r == TMR_LAST) begin
          state_next_s = FAULT;
        end else begin
          timer_next_s = timer_r + TMR_ONE;
        end
      end
      REL: begin
        // Decide on the post-update count so that change arriving now keeps the payout going
        if (!hopper_ack) begin
          if (pending_next_s != PEND_ZERO) begin
            state_next_s = REQ;
          end else begin
            state_next_s = IDLE;
          end
        end else if (timer_r == TMR_LAST) begin
          state_next_s = FAULT;
        end else begin
          timer_next_s = timer_r + TMR_ONE;
        end
      end
      FAULT: begin
        state_next_s = FAULT;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  pulse_stretch #(
    .PULSE_LEN(DRINK_PULSE)
  ) u_drink_pulse (
    .clk        (clk),
    .rst        (rst),
    .load       (drink),
    .pulse      (drink_motor),
    .pulse_next (motor_next_s)
  );

  // State, counters and registered outputs. Outputs take their next-state values so that they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      timer_r      <= TMR_ZERO;
      pending_r    <= PEND_ZERO;
      overflow_r   <= 1'b0;
      fault_r      <= 1'b0;
      hopper_req_r <= 1'b0;
      busy_r       <= 1'b0;
      coins_paid_r <= PAID_ZERO;
    end else begin
      state_r      <= state_next_s;
      timer_r      <= timer_next_s;
      pending_r    <= pending_next_s;
      overflow_r   <= overflow_r | sat_s;
      fault_r      <= fault_r | (state_next_s == FAULT);
      hopper_req_r <= (state_next_s == REQ);
      busy_r       <= (pending_next_s != PEND_ZERO) || (state_next_s != IDLE) || motor_next_s;
      coins_paid_r <= coins_paid_r + PAID_W'(dec_s);
    end
  end

  assign hopper_req = hopper_req_r;
  assign pending    = pending_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign fault      = fault_r;
  assign coins_paid = coins_paid_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser. It uses a hopper model with selectable
// ack behaviour. Scoreboard queues hold the expected coins_paid value for
// each coin and the expected length of each motor pulse. Expected values are
// pushed when the stimulus is driven and compared when the DUT produces the
// event.
module tb_change_dispenser;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] change = 2'd0;
  logic       drink = 1'b0;
  logic       hopper_ack = 1'b0;
  logic       hopper_req;
  logic       drink_motor;
  logic [3:0] pending;
  logic       busy;
  logic       overflow;
  logic       fault;
  logic [7:0] coins_paid;

  change_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .change     (change),
    .drink      (drink),
    .hopper_ack (hopper_ack),
    .hopper_req (hopper_req),
    .drink_motor(drink_motor),
    .pending    (pending),
    .busy       (busy),
    .overflow   (overflow),
    .fault      (fault),
    .coins_paid (coins_paid)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit in_reset     = 1'b1;
  int hmode        = 0;   // 0: ack mirrors req, 1: ack one cycle after req, 2: never ack
  logic req_d      = 1'b0;

  int paid_q[$];
  int pulse_q[$];
  int prev_paid = 0;
  int last_done = 0;
  int prev_done = 0;
  int motor_run = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // cycle counter
  always @(posedge clk) cyc++;

  // hopper model
  always @(negedge clk) begin
    case (hmode)
      0:       hopper_ack = hopper_req;
      1:       hopper_ack = req_d;
      default: hopper_ack = 1'b0;
    endcase
    req_d = hopper_req;
  end

  // coin completion monitor
  always @(negedge clk) begin
    if (!in_reset && int'(coins_paid) != prev_paid) begin
      prev_done = last_done;
      last_done = cyc;
      if (paid_q.size() == 0) check("paid_unexpected", coins_paid, prev_paid);
      else check("paid", coins_paid, paid_q.pop_front());
    end
    prev_paid = int'(coins_paid);
  end

  // drink pulse length monitor
  always @(negedge clk) begin
    if (in_reset) begin
      motor_run = 0;
    end else if (drink_motor) begin
      motor_run++;
    end else if (motor_run != 0) begin
      if (pulse_q.size() == 0) check("pulse_unexpected", motor_run, 0);
      else check("pulse_len", motor_run, pulse_q.pop_front());
      motor_run = 0;
    end
  end

  task automatic do_reset(input int mode);
    in_reset = 1'b1;
    rst      = 1'b1;
    change   = 2'd0;
    drink    = 1'b0;
    hmode    = mode;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    in_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int n;
    logic seen;

    // Reset state and single coin, hopper acks one cycle after req
    do_reset(1);
    check("reset_outputs", {hopper_req, drink_motor, pending, busy, overflow, fault, coins_paid}, 0);
    change = COIN_1;
    paid_q.push_back(1);
    @(negedge clk);
    change = COIN_0;
    check("t1_pending", pending, 1);
    check("t1_req_low", hopper_req, 0);
    @(negedge clk);
    check("t1_req_high", hopper_req, 1);
    wait_idle("t1_idle", 40);
    check("t1_pending_end", pending, 0);
    check("t1_paid", coins_paid, 1);
    check("t1_busy", busy, 0);

    // Burst of two coins plus a vend in the same cycle, immediate hopper
    do_reset(0);
    change = COIN_2;
    drink  = 1'b1;
    paid_q.push_back(1);
    paid_q.push_back(2);
    pulse_q.push_back(4);
    @(negedge clk);
    change = COIN_0;
    drink  = 1'b0;
    check("t2_motor_rise", drink_motor, 1);
    check("t2_pending", pending, 2);
    wait_idle("t2_idle", 40);
    check("t2_paid", coins_paid, 2);
    check("t2_gap", last_done - prev_done, 2);

    // Change arriving on the edge where REL completes with pending=1
    do_reset(0);
    change = COIN_1;
    paid_q.push_back(1);
    paid_q.push_back(2);
    @(negedge clk);
    change = COIN_0;
    @(negedge clk);
    @(negedge clk);
    change = COIN_1;
    @(negedge clk);
    change = COIN_0;
    check("t3_pending", pending, 1);
    check("t3_req", hopper_req, 1);
    check("t3_paid", coins_paid, 1);
    wait_idle("t3_idle", 40);
    check("t3_paid_end", coins_paid, 2);

    // Saturation with a hopper that never acks
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      change = COIN_2;
      @(negedge clk);
      if (i == 6) begin
        check("t4_pending_14", pending, 14);
        check("t4_no_ovf_yet", overflow, 0);
      end
    end
    change = COIN_0;
    check("t4_pending_sat", pending, 15);
    check("t4_overflow", overflow, 1);

    // Timeout: count cycles with req high
    do_reset(2);
    change = COIN_1;
    @(negedge clk);
    change = COIN_0;
    hi = 0;
    n  = 0;
    while (n < 40) begin
      @(negedge clk);
      if (hopper_req) hi++;
      else if (hi != 0) break;
      n++;
    end
    check("t5_req_cycles", hi, 16);
    check("t5_fault", fault, 1);
    check("t5_pending", pending, 1);
    change = COIN_1;
    @(negedge clk);
    change = COIN_0;
    check("t5_pending_after", pending, 2);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | hopper_req;
    end
    check("t5_req_stays_low", seen, 0);
    check("t5_fault_sticky", fault, 1);

    // Illegal code, then reset in the middle of REQ
    do_reset(0);
    change = COIN_BAD;
    repeat (3) @(negedge clk);
    change = COIN_0;
    check("t6_bad_pending", pending, 0);
    check("t6_bad_overflow", overflow, 0);
    check("t6_bad_busy", busy, 0);
    hmode  = 2;
    change = COIN_1;
    drink  = 1'b1;
    @(negedge clk);
    change = COIN_0;
    drink  = 1'b0;
    @(negedge clk);
    check("t6_in_req", hopper_req, 1);
    in_reset = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    check("t6_reset_outputs", {hopper_req, drink_motor, pending, busy, overflow, fault, coins_paid}, 0);
    rst = 1'b0;
    @(posedge clk);
    in_reset = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_paid_empty", paid_q.size(), 0);
    check("sb_pulse_empty", pulse_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
